regfile_writer: RTL and testbench
=================================

REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 The module SHALL have parameter width, default 16, setting the data and register bit width.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 wr_valid  input  1  producer presents a write request.
REQ-005 wr_ready  output  1  block can accept a request this cycle.
REQ-006 writenum  input  3  destination register index of the request.
REQ-007 data_in  input  width  value to write.
REQ-008 hold  input  1  when high, draining into the register file is suspended.
REQ-009 readnum  input  3  register index currently being read by the consumer.
REQ-010 hazard  output  1  a queued write targets readnum.
REQ-011 pending  output  1  at least one write is queued.
REQ-012 reg0 .. reg7  output  width each  architectural register contents.

Function
REQ-013 Requests SHALL be held in a 2-entry in-order queue; each entry stores writenum and data_in.
REQ-014 wr_ready SHALL be 1 when the queue holds fewer than 2 entries, 0 when it holds 2; it depends only on queue occupancy, never on wr_valid or hold.
REQ-015 A request SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1; wr_valid=1 with wr_ready=0 SHALL be ignored and the producer keeps it stable.
REQ-016 On each rising edge where the queue is non-empty and hold=0, the head entry SHALL be written to reg[head.writenum] and popped.
REQ-017 At most one register SHALL be updated per edge; all other registers retain their value.
REQ-018 A request accepted at edge N into an empty queue SHALL update its register at edge N+1 if hold=0 at N+1; no same-edge bypass from data_in to the registers.
REQ-019 Push and pop on the same edge SHALL both take effect; occupancy stays unchanged (occupancy 1 stays 1; occupancy 2 cannot push, per REQ-014).
REQ-020 Entries SHALL be applied strictly in acceptance order; two queued writes to the same index leave the later value in the register.
REQ-021 While hold=1, the queue SHALL still accept requests until full; no register changes.
REQ-022 pending SHALL equal (occupancy != 0), registered state only.
REQ-023 hazard SHALL be combinational: 1 iff any valid queue entry has writenum equal to readnum; 0 when the queue is empty.
REQ-024 hazard SHALL not consider the current-cycle wr_valid/writenum input, only accepted entries.
REQ-025 Queue pointers SHALL wrap modulo 2; occupancy SHALL never exceed 2 nor underflow below 0.
REQ-026 All outputs except hazard and wr_ready SHALL be driven from flops.

Reset
REQ-027 reset_n=0 SHALL immediately, independent of clk, clear reg0..reg7 to 0, empty the queue, and force pending=0, hazard=0, wr_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all queued writes; none are applied after release.
REQ-029 The first edge after reset_n rises SHALL be able to accept a request.

Verification
REQ-030 Reset, then wr_valid=1, writenum=3, data_in=16'h00A5 for one edge, hold=0 -> pending=1 after that edge, reg3=16'h00A5 one edge later, pending=0, other regs 0.
REQ-031 hold=1, push writenum=5 data 16'h1111 then writenum=5 data 16'h2222 -> wr_ready=0 after second push, third request ignored; release hold -> reg5=16'h1111 then 16'h2222 on consecutive edges, wr_ready=1 after first drain.
REQ-032 hold=1, queue holds writes to 2 and 6; sweep readnum 0..7 -> hazard=1 only for readnum 2 and 6.
REQ-033 Continuous back-to-back pushes writenum=0..7 data 16'h0100*index, hold=0 -> one accept and one drain per edge, occupancy stays 1, reg[i]=16'h0100*i in order.
REQ-034 Queue full with hold=1, assert reset_n=0 between edges -> registers 0, pending=0, wr_ready=1 immediately; after release with hold=0 no register changes.

Source files
------------

// File: rtl/regfile_writer.sv
// Buffered write port for an 8-entry register file: a 2-deep in-order queue
// absorbs write requests and drains one per clock unless hold is asserted.
module regfile_writer #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       writenum,
    input  logic [width-1:0] data_in,
    input  logic             hold,
    input  logic [2:0]       readnum,
    output logic             hazard,
    output logic             pending,
    output logic [width-1:0] reg0,
    output logic [width-1:0] reg1,
    output logic [width-1:0] reg2,
    output logic [width-1:0] reg3,
    output logic [width-1:0] reg4,
    output logic [width-1:0] reg5,
    output logic [width-1:0] reg6,
    output logic [width-1:0] reg7
);

    logic [width-1:0] regs [8];
    logic [2:0]       q_num  [2];
    logic [width-1:0] q_data [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             pop;

    assign wr_ready = (count != 2'd2);
    assign push     = wr_valid && wr_ready;
    assign pop      = (count != 2'd0) && !hold;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Only accepted entries count; the head is valid whenever the queue is
    // non-empty, the slot behind it only when the queue is full.
    always_comb begin
        hazard = 1'b0;
        if (count != 2'd0 && q_num[head] == readnum)
            hazard = 1'b1;
        if (count == 2'd2 && q_num[~head] == readnum)
            hazard = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                q_num[i]  <= '0;
                q_data[i] <= '0;
            end
            head    <= 1'b0;
            tail    <= 1'b0;
            count   <= 2'd0;
            pending <= 1'b0;
        end else begin
            if (push) begin
                q_num[tail]  <= writenum;
                q_data[tail] <= data_in;
                tail         <= ~tail;
            end
            if (pop) begin
                regs[q_num[head]] <= q_data[head];
                head              <= ~head;
            end
            count   <= count_next;
            pending <= (count_next != 2'd0);
        end
    end

    assign reg0 = regs[0];
    assign reg1 = regs[1];
    assign reg2 = regs[2];
    assign reg3 = regs[3];
    assign reg4 = regs[4];
    assign reg5 = regs[5];
    assign reg6 = regs[6];
    assign reg7 = regs[7];

endmodule

// File: tb/tb_regfile_writer.sv
// Directed self-checking bench for regfile_writer: single write, hold/backpressure,
// hazard sweep, back-to-back streaming, and mid-operation reset.
module tb_regfile_writer;

    logic        clk;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        hold;
    logic [2:0]  readnum;
    logic        hazard;
    logic        pending;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] obs [8];
    logic [15:0] model [8];
    int          checks;
    int          errors;

    regfile_writer #(.width(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .writenum (writenum),
        .data_in  (data_in),
        .hold     (hold),
        .readnum  (readnum),
        .hazard   (hazard),
        .pending  (pending),
        .reg0     (r0),
        .reg1     (r1),
        .reg2     (r2),
        .reg3     (r3),
        .reg4     (r4),
        .reg5     (r5),
        .reg6     (r6),
        .reg7     (r7)
    );

    assign obs[0] = r0;
    assign obs[1] = r1;
    assign obs[2] = r2;
    assign obs[3] = r3;
    assign obs[4] = r4;
    assign obs[5] = r5;
    assign obs[6] = r6;
    assign obs[7] = r7;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_reg%0d", tag, i), {16'h0, obs[i]}, {16'h0, model[i]});
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        writenum = 3'd0;
        data_in  = 16'h0;
        hold     = 1'b0;
        readnum  = 3'd0;
        for (int i = 0; i < 8; i++)
            model[i] = 16'h0;

        #3;
        check("rst_pending", {31'h0, pending}, 32'd0);
        check("rst_hazard", {31'h0, hazard}, 32'd0);
        check("rst_ready", {31'h0, wr_ready}, 32'd1);
        check_regs("rst");
        #9 reset_n = 1'b1;

        // Single write to r3
        wr_valid = 1'b1; writenum = 3'd3; data_in = 16'h00A5; readnum = 3'd3;
        step();
        wr_valid = 1'b0;
        check("single_pending", {31'h0, pending}, 32'd1);
        check("single_hazard", {31'h0, hazard}, 32'd1);
        check("single_no_bypass", {16'h0, r3}, 32'h0);
        step();
        model[3] = 16'h00A5;
        check("single_pending_clear", {31'h0, pending}, 32'd0);
        check("single_hazard_clear", {31'h0, hazard}, 32'd0);
        check_regs("single");

        // Fill under hold, third request must be ignored
        hold = 1'b1;
        wr_valid = 1'b1; writenum = 3'd5; data_in = 16'h1111;
        step();
        check("hold_ready_one", {31'h0, wr_ready}, 32'd1);
        data_in = 16'h2222;
        step();
        check("hold_ready_full", {31'h0, wr_ready}, 32'd0);
        data_in = 16'h3333;
        step();
        check("hold_ready_still_full", {31'h0, wr_ready}, 32'd0);
        check("hold_reg5_unchanged", {16'h0, r5}, 32'h0);
        wr_valid = 1'b0;
        hold = 1'b0;
        step();
        check("drain1_reg5", {16'h0, r5}, 32'h1111);
        check("drain1_ready", {31'h0, wr_ready}, 32'd1);
        check("drain1_pending", {31'h0, pending}, 32'd1);
        step();
        model[5] = 16'h2222;
        check("drain2_pending", {31'h0, pending}, 32'd0);
        check_regs("drain2");

        // Hazard sweep over two queued entries
        hold = 1'b1;
        wr_valid = 1'b1; writenum = 3'd2; data_in = 16'h0202;
        step();
        writenum = 3'd6; data_in = 16'h0606;
        step();
        wr_valid = 1'b0;
        writenum = 3'd4;
        for (int r = 0; r < 8; r++) begin
            readnum = 3'(r);
            #1;
            check($sformatf("hazard_rd%0d", r), {31'h0, hazard}, (r == 2 || r == 6) ? 32'd1 : 32'd0);
        end
        check_regs("hazard_hold");
        hold = 1'b0;
        readnum = 3'd0;
        step();
        step();
        model[2] = 16'h0202;
        model[6] = 16'h0606;
        check_regs("hazard_drain");

        // Back-to-back streaming, one accept and one drain per edge
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; writenum = 3'(i); data_in = 16'(i << 8);
            step();
            check($sformatf("stream_pending%0d", i), {31'h0, pending}, 32'd1);
            check($sformatf("stream_ready%0d", i), {31'h0, wr_ready}, 32'd1);
            if (i > 0) begin
                model[i-1] = 16'((i - 1) << 8);
                check($sformatf("stream_reg%0d", i - 1), {16'h0, obs[i-1]}, {16'h0, model[i-1]});
            end
        end
        wr_valid = 1'b0;
        step();
        model[7] = 16'h0700;
        check("stream_end_pending", {31'h0, pending}, 32'd0);
        check_regs("stream");

        // Reset while full and held, between edges
        hold = 1'b1;
        wr_valid = 1'b1; writenum = 3'd1; data_in = 16'hBEEF;
        step();
        writenum = 3'd4; data_in = 16'hCAFE;
        step();
        wr_valid = 1'b0;
        readnum = 3'd1;
        check("full_ready", {31'h0, wr_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++)
            model[i] = 16'h0;
        check("midrst_pending", {31'h0, pending}, 32'd0);
        check("midrst_ready", {31'h0, wr_ready}, 32'd1);
        check("midrst_hazard", {31'h0, hazard}, 32'd0);
        check_regs("midrst");
        #2 reset_n = 1'b1;
        hold = 1'b0;
        step();
        step();
        check("postrst_pending", {31'h0, pending}, 32'd0);
        check_regs("postrst");

        // First edge after release accepts
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        wr_valid = 1'b1; writenum = 3'd7; data_in = 16'h7777;
        step();
        wr_valid = 1'b0;
        check("first_edge_pending", {31'h0, pending}, 32'd1);
        step();
        model[7] = 16'h7777;
        check_regs("first_edge");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
